// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind valid/ready request and
// response channels, with a fixed number of wait states per access and an
// error response for addresses beyond the RAM depth.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        cnt;
    logic [3:0]        next_cnt;
    logic              capture;
    logic              do_access;

    // Request fields latched at the accept edge; the requester may change
    // its outputs freely while we are busy.
    logic              cap_we;
    logic [31:0]       cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;

    // Operands of the access actually performed on this edge.
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    logic [31:0]       mem [DEPTH];

    assign req_ready = (state == IDLE);

    // Next-state, counter and access-strobe decode.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        do_access  = 1'b0;
        acc_we     = cap_we;
        acc_addr   = cap_addr;
        acc_wdata  = cap_wdata;
        acc_be     = cap_be;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: access straight from the request bus.
                        do_access  = 1'b1;
                        acc_we     = req_we;
                        acc_addr   = req_addr;
                        acc_wdata  = req_wdata;
                        acc_be     = req_be;
                        next_state = RESP;
                    end else begin
                        next_cnt   = 4'(WAIT_CYCLES);
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    do_access  = 1'b1;
                    next_cnt   = 4'd0;
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
        // Never touch the RAM while reset is held.
        if (!reset) begin
            do_access = 1'b0;
            capture   = 1'b0;
        end
    end

    assign acc_err = ((acc_addr >> ADDR_W) != 32'd0);
    assign acc_idx = acc_addr[ADDR_W-1:0];

    // Control state: FSM, wait counter and the registered response valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            rsp_valid <= (next_state == RESP);
        end
    end

    // Response payload, written only on the access edge so it holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (do_access) begin
            rsp_err <= acc_err;
            if (!acc_we && !acc_err) begin
                rsp_rdata <= mem[acc_idx];
            end else begin
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Request capture at the accept edge (data path, not reset).
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Byte-lane store into the RAM; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, backpressure and reset
// sequences on a WAIT_CYCLES=2 instance, a streaming check on a WAIT_CYCLES=0
// instance, and randomized traffic against a reference memory model.
module tb_dmem_responder;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_rsp_valid, z_rsp_ready = 1'b0, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];
    vec_t zvecs[6];
    logic [31:0] model[16];

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=response", name);
    endtask

    // One complete transaction on the WAIT_CYCLES=2 instance.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er);
        int lat;
        bit got;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            if (rsp_valid) got = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!got) begin
            timeout("rsp_wait");
            rsp_ready = 1'b1;
            return;
        end
        chk("latency", lat, WC);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          zi;
        int          cyc;
        bit          acc;
        bit          got;

        vecs[0]  = '{1'b1, 32'd5,     32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,     32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd5,     32'h00001234, 4'h3, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'd5,     32'h0,        4'h0, 32'hDEAD1234, 1'b0};
        vecs[4]  = '{1'b1, 32'd5,     32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'd5,     32'h0,        4'hF, 32'hDEAD1234, 1'b0};
        vecs[6]  = '{1'b1, 32'd0,     32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h400,   32'h00000001, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'd0,     32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 32'h400,   32'h0,        4'h0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'd7,     32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'd7,     32'hAB00CD00, 4'hA, 32'h0,        1'b0};

        zvecs[0] = '{1'b1, 32'd1,     32'h11111111, 4'hF, 32'h0,        1'b0};
        zvecs[1] = '{1'b1, 32'd2,     32'h22222222, 4'hF, 32'h0,        1'b0};
        zvecs[2] = '{1'b0, 32'd1,     32'h0,        4'h0, 32'h11111111, 1'b0};
        zvecs[3] = '{1'b0, 32'd2,     32'h0,        4'h0, 32'h22222222, 1'b0};
        zvecs[4] = '{1'b0, 32'h800,   32'h0,        4'h0, 32'h0,        1'b1};
        zvecs[5] = '{1'b0, 32'd1,     32'h0,        4'h0, 32'h11111111, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_z_req_ready", {31'd0, z_req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait instance: back-to-back requests, one response every 2 cycles
        zi = 0; cyc = 0;
        z_rsp_ready = 1'b1;
        while (zi < 6 && cyc < 30) begin
            @(negedge clk);
            z_req_valid = 1'b1;
            z_req_we = zvecs[zi].we; z_req_addr = zvecs[zi].addr;
            z_req_wdata = zvecs[zi].wdata; z_req_be = zvecs[zi].be;
            acc = z_req_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                chk("z_valid", {31'd0, z_rsp_valid}, 32'd1);
                chk("z_rdata", z_rsp_rdata, zvecs[zi].exp_rd);
                chk("z_err", {31'd0, z_rsp_err}, {31'd0, zvecs[zi].exp_err});
                zi++;
            end else begin
                chk("z_gap_valid", {31'd0, z_rsp_valid}, 32'd0);
            end
        end
        z_req_valid = 1'b0;
        if (zi < 6) timeout("z_stream");
        chk("z_cycles", cyc, 11);

        // Directed vectors
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        end
        txn(1'b0, 32'd7, 32'h0, 4'h0, 0, rd, er);
        chk("partial_hi_lanes", rd, 32'hAB34CD78);

        // Backpressure: response held for 5 cycles
        txn(1'b0, 32'd5, 32'h0, 4'h0, 5, rd, er);
        chk("bp_rdata", rd, 32'hDEAD1234);
        chk("bp_err", {31'd0, er}, 32'd0);

        // Reset while a store waits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 32'd7, 32'h0, 4'h0, 0, rd, er);
        chk("after_rst_ld7", rd, 32'hAB34CD78);

        // Reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5; req_be = 4'h0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) got = 1;
        end
        if (!got) timeout("resp_rst_wait");
        else chk("resp_pending_rdata", rsp_rdata, 32'hDEAD1234);
        reset = 1'b0;
        #1;
        chk("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("resp_rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1;

        // Randomized traffic against the reference memory
        for (int a = 0; a < 16; a++) begin
            model[a] = $urandom;
            txn(1'b1, a, model[a], 4'hF, 0, rd, er);
            chk("init_rdata", rd, 32'd0);
            chk("init_err", {31'd0, er}, 32'd0);
        end
        for (int n = 0; n < 120; n++) begin
            logic        we;
            logic [31:0] addr, wdata, exp_rd;
            logic [3:0]  be;
            logic        exp_err;
            we = 1'($urandom);
            wdata = $urandom;
            be = 4'($urandom);
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h400;
            else addr = $urandom_range(0, 15);
            exp_err = (addr >= 32'd1024);
            exp_rd = (!we && !exp_err) ? model[addr[3:0]] : 32'd0;
            if (we && !exp_err)
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
            txn(we, addr, wdata, be, $urandom_range(0, 2), rd, er);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, exp_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder that services load/store requests from the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds the data RAM and inserts a configurable number of wait states per access. Out-of-range addresses produce an error response. It is the memory-side counterpart to the MEM-stage access port, and replaces the single-cycle combinational data memory when a multi-cycle memory model is needed.

## Interface
- ADDR_W, 10: word-address width; depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states per access, legal range 0..15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  word address (not byte address).
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be. If WAIT_CYCLES=0, perform the access on the same edge and go to RESP. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT: req_ready=0. Each edge, if cnt==1, perform the access and go to RESP; else decrement cnt.
- Access:
  - err = (addr[31:ADDR_W] != 0).
  - Load: rdata_reg = mem[addr[ADDR_W-1:0]] when err=0, else 0.
  - Store: write only the enabled byte lanes when err=0. rdata_reg = 0.
  - be=4'b0000 store leaves memory unchanged and is still acknowledged.
  - Load ignores be.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- Request fields may change freely while req_ready=0. They are sampled only at the accept edge.
- Outputs rsp_valid, rsp_rdata and rsp_err are registered. req_ready is decoded from state (IDLE).

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0, state IDLE. RAM contents are not cleared by reset.
- Latency: for a request accepted at edge k, rsp_valid rises after edge k+WAIT_CYCLES. It is visible WAIT_CYCLES+1 cycles after the request cycle.
- Best-case throughput: one transaction per WAIT_CYCLES+2 cycles. req_ready returns high the cycle after the response handshake, with no overlap.
- rsp_ready held low: the FSM stays in RESP indefinitely and the response stays stable.
- rsp_ready held high permanently: the response lasts exactly one cycle.
- Reset mid-operation (in WAIT): the transaction is dropped and no store is committed. In RESP, the pending response is discarded. A store already committed at or before the access edge is retained.
- Reset asserted asynchronously forces outputs to their reset values immediately. Release is synchronous to the next edge.
- Read-after-write: a load accepted after a store's response returns the new data.

## Test plan
- Reset, WAIT_CYCLES=2: store addr=5, wdata=32'hDEADBEEF, be=4'hF → rsp_valid 3 cycles after the request cycle, rdata=0, err=0. Then load addr=5 → rdata=32'hDEADBEEF.
- Partial store: after the above, store addr=5, wdata=32'h00001234, be=4'b0011 → load addr=5 returns 32'hDEAD1234. A be=0 store leaves the value unchanged.
- Out of range, ADDR_W=10: store addr=32'h400, wdata=1 → err=1, rdata=0. Load addr=0 is unaffected (no aliasing). Load addr=32'h400 → err=1, rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rdata and err stay stable and req_ready stays 0. Raise rsp_ready → handshake occurs, req_ready=1 the next cycle.
- WAIT_CYCLES=0: back-to-back loads with rsp_ready=1 → one response every 2 cycles, latency 1 cycle.
- Assert reset low during WAIT of a store to addr=7 (wdata=32'hFFFFFFFF) → outputs reset immediately. A later load of addr=7 returns the previous contents.
